pipeline_stall_controller: RTL and testbench

//   Consumer of the hazard unit's stall request plus branch/halt/debug events; sole source of the

---
 rtl/pipeline_stall_controller.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller.
// This block is the only source of the PC and IF/ID write enables, the IF/ID flush,
// the ID/EX bubble and the global stage enable. It sequences run, single-step,
// HALT draining and debug halting. It also runs a consecutive-stall watchdog and
// keeps two saturating event counters.
module pipeline_stall_controller #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_LIMIT  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic             i_halt_instr,
  input  logic             i_dbg_run,
  input  logic             i_dbg_step,
  input  logic             i_dbg_halt_req,
  output logic             o_pipe_en,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_halted,
  output logic             o_prog_end,
  output logic             o_stall_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // Drain down-counter holds DRAIN_CYCLES-1 .. 0; the watchdog counts up to STALL_LIMIT-1.
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WD_W  = $clog2(STALL_LIMIT + 1);
  localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_TRIP    = WD_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             prog_end_q, prog_end_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic issuing;      // RUN or STEP: the hazard/branch/halt inputs are honoured
  logic stall_apply;  // a hazard stall is being applied this cycle
  logic halt_decode;  // HALT accepted this cycle (a stall takes precedence over it)
  logic wd_trip;      // this stalled RUN cycle completes the watchdog limit

  // The counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Decode the qualifying conditions that both the gating and the next-state logic share.
  always_comb begin
    issuing     = (state_q == ST_RUN) || (state_q == ST_STEP);
    stall_apply = issuing && i_stall;
    halt_decode = issuing && !i_stall && i_halt_instr;
    wd_trip     = (state_q == ST_RUN) && i_stall && (wd_cnt_q == WD_TRIP);
  end

  // Zero-latency gating outputs from the current state and the event inputs.
  always_comb begin
    o_pipe_en      = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_halted       = (state_q == ST_HALTED);
    case (state_q)
      ST_RUN, ST_STEP: begin
        o_pipe_en = 1'b1;
        if (i_stall) begin
          // A stall wins over a taken branch: its operands are not ready yet.
          o_id_ex_bubble = 1'b1;
        end else if (i_halt_instr) begin
          // HALT is not issued. It is replaced by a bubble while the older instructions drain.
          o_id_ex_bubble = 1'b1;
        end else if (i_branch_taken) begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_if_id_flush = 1'b1;
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_pipe_en      = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and bookkeeping: state transitions, drain countdown, watchdog, stickies, counters.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    prog_end_d  = prog_end_q;
    timeout_d   = timeout_q | wd_trip;
    stall_cnt_d = stall_apply   ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = o_if_id_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;

    // The watchdog tracks only unbroken runs of stalled RUN cycles.
    if ((state_q == ST_RUN) && i_stall && !wd_trip) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_d = '0;
    end

    case (state_q)
      ST_HALTED: begin
        // Run wins over step. A new run also starts a new program, so prog_end is cleared.
        if (i_dbg_run) begin
          state_d    = ST_RUN;
          prog_end_d = 1'b0;
        end else if (i_dbg_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (i_dbg_halt_req || !i_dbg_run || wd_trip) begin
          state_d = ST_HALTED;
        end else if (halt_decode) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end
      end
      ST_STEP: begin
        // A step grants exactly one enabled cycle. A HALT decoded in that cycle still drains.
        if (halt_decode && !i_dbg_halt_req) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_DRAIN: begin
        // A debug halt abandons the drain, so the program is not marked as ended.
        if (i_dbg_halt_req) begin
          state_d = ST_HALTED;
        end else if (drain_cnt_q == '0) begin
          state_d    = ST_HALTED;
          prog_end_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - DRN_W'(1);
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // State register. Reset returns the block to HALTED with all counts and flags clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_HALTED;
      drain_cnt_q <= '0;
      wd_cnt_q    <= '0;
      prog_end_q  <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      prog_end_q  <= prog_end_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_prog_end      = prog_end_q;
  assign o_stall_timeout = timeout_q;
  assign o_stall_cnt     = stall_cnt_q;
  assign o_flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller.
// Expected gating vectors go into a scoreboard queue as each cycle is driven.
// A negedge monitor pops and compares them. Counters and sticky flags are checked inline.
module tb_pipeline_stall_controller;

  // Input pattern bits: {stall, branch, halt_instr, dbg_run, dbg_step, dbg_halt_req}
  localparam logic [5:0] I_ST = 6'b100000;
  localparam logic [5:0] I_BR = 6'b010000;
  localparam logic [5:0] I_HT = 6'b001000;
  localparam logic [5:0] I_RN = 6'b000100;
  localparam logic [5:0] I_SP = 6'b000010;
  localparam logic [5:0] I_HR = 6'b000001;
  localparam logic [5:0] I_NO = 6'b000000;
  // Output vector bits: {pipe_en, pc_write, if_id_write, flush, bubble, halted}
  localparam logic [5:0] HALT_O  = 6'b000001;
  localparam logic [5:0] RUN_O   = 6'b111000;
  localparam logic [5:0] STALL_O = 6'b100010;
  localparam logic [5:0] BR_O    = 6'b111100;
  localparam logic [5:0] DRN_O   = 6'b100010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic stall = 1'b0, br = 1'b0, halt = 1'b0, run = 1'b0, step = 1'b0, hreq = 1'b0;
  logic pipe_en, pc_write, if_id_write, flush, bubble, halted, prog_end, timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic pipe_en2, pc_write2, if_id_write2, flush2, bubble2, halted2, prog_end2, timeout2;
  logic [1:0] stall_cnt2, flush_cnt2;
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign obs = {pipe_en, pc_write, if_id_write, flush, bubble, halted};

  pipeline_stall_controller #(.CNT_W(16), .DRAIN_CYCLES(4), .STALL_LIMIT(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_branch_taken(br),
    .i_halt_instr(halt), .i_dbg_run(run), .i_dbg_step(step), .i_dbg_halt_req(hreq),
    .o_pipe_en(pipe_en), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(flush), .o_id_ex_bubble(bubble), .o_halted(halted),
    .o_prog_end(prog_end), .o_stall_timeout(timeout),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  pipeline_stall_controller #(.CNT_W(2), .DRAIN_CYCLES(4), .STALL_LIMIT(8)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_stall(stall), .i_branch_taken(br),
    .i_halt_instr(halt), .i_dbg_run(run), .i_dbg_step(step), .i_dbg_halt_req(hreq),
    .o_pipe_en(pipe_en2), .o_pc_write(pc_write2), .o_if_id_write(if_id_write2),
    .o_if_id_flush(flush2), .o_id_ex_bubble(bubble2), .o_halted(halted2),
    .o_prog_end(prog_end2), .o_stall_timeout(timeout2),
    .o_stall_cnt(stall_cnt2), .o_flush_cnt(flush_cnt2)
  );

  // Scoreboard consumer: compare this cycle's gating outputs mid-cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: {pipe_en,pc_wr,ifid_wr,flush,bubble,halted} got %b expected %b",
                 e.tag, obs, e.v);
      end
    end
  end

  // Drive one cycle of inputs and queue the gating vector expected during it
  task automatic cyc(input logic [5:0] in, input logic [5:0] exp_v, input string tag);
    exp_t e;
    {stall, br, halt, run, step, hreq} = in;
    e.v = exp_v;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== HALT_O) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, HALT_O);
    end
    n_checks++;
    if ({prog_end, timeout} !== 2'b00) begin
      n_fail++; $display("FAIL reset_stickies: got %b expected 00", {prog_end, timeout});
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_run();
    cyc(I_RN, HALT_O, "run_from_halted");
    for (int i = 0; i < 4; i++) cyc(I_RN, RUN_O, "run_free");
  endtask

  task automatic test_stall_branch();
    cyc(I_RN | I_ST | I_BR, STALL_O, "stall_beats_branch");
    n_checks++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stall_cnt_after_stall: got %0d/%0d expected 1/0", stall_cnt, flush_cnt);
    end
    cyc(I_RN, RUN_O, "run_after_stall");
  endtask

  task automatic test_branch();
    cyc(I_RN | I_BR, BR_O, "branch_flush");
    n_checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL flush_cnt_after_branch: got %0d/%0d expected 1/1", flush_cnt, stall_cnt);
    end
    cyc(I_RN, RUN_O, "run_after_branch");
  endtask

  task automatic test_halt_drain();
    cyc(I_RN | I_HT, DRN_O, "halt_decode");
    cyc(I_RN | I_ST | I_BR, DRN_O, "drain_1_ignores_events");
    cyc(I_RN, DRN_O, "drain_2");
    cyc(I_RN, DRN_O, "drain_3");
    n_checks++;
    if (prog_end !== 1'b0) begin
      n_fail++; $display("FAIL prog_end_early: got %b expected 0", prog_end);
    end
    cyc(I_RN, DRN_O, "drain_4");
    cyc(I_NO, HALT_O, "halted_after_drain");
    n_checks++;
    if (prog_end !== 1'b1) begin
      n_fail++; $display("FAIL prog_end_set: got %b expected 1", prog_end);
    end
    n_checks++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin
      n_fail++; $display("FAIL counters_after_drain: got %0d/%0d expected 1/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      cyc(I_SP, HALT_O, "step_pulse");
      cyc(I_NO, RUN_O, "step_cycle");
    end
    cyc(I_NO, HALT_O, "halted_after_steps");
    cyc(I_SP, HALT_O, "step_pulse_halt");
    cyc(I_HT, DRN_O, "step_halt_decode");
    for (int i = 0; i < 4; i++) cyc(I_NO, DRN_O, "step_drain");
    cyc(I_NO, HALT_O, "halted_after_step_drain");
    n_checks++;
    if (prog_end !== 1'b1) begin
      n_fail++; $display("FAIL prog_end_after_step: got %b expected 1", prog_end);
    end
  endtask

  task automatic test_dbg_halt();
    cyc(I_RN, HALT_O, "rerun");
    n_checks++;
    if (prog_end !== 1'b0) begin
      n_fail++; $display("FAIL prog_end_clear_on_run: got %b expected 0", prog_end);
    end
    cyc(I_RN, RUN_O, "run_before_hreq");
    cyc(I_RN | I_HR | I_BR, BR_O, "hreq_keeps_gating");
    cyc(I_NO, HALT_O, "halted_by_hreq");
    n_checks++;
    if (flush_cnt !== 16'd2) begin
      n_fail++; $display("FAIL flush_cnt_hreq: got %0d expected 2", flush_cnt);
    end
    cyc(I_RN, HALT_O, "rerun2");
    cyc(I_RN, RUN_O, "run_before_drop");
    cyc(I_NO, RUN_O, "run_dropped");
    cyc(I_NO, HALT_O, "halted_by_run_low");
    cyc(I_RN, HALT_O, "rerun3");
    cyc(I_RN | I_HT, DRN_O, "halt_decode_for_abort");
    cyc(I_HR, DRN_O, "drain_hreq");
    cyc(I_NO, HALT_O, "halted_drain_abort");
    n_checks++;
    if (prog_end !== 1'b0) begin
      n_fail++; $display("FAIL prog_end_after_abort: got %b expected 0", prog_end);
    end
  endtask

  task automatic test_watchdog();
    cyc(I_RN, HALT_O, "wd_start");
    for (int i = 0; i < 7; i++) cyc(I_RN | I_ST, STALL_O, "wd_stall7");
    cyc(I_RN, RUN_O, "wd_break");
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout);
    end
    for (int i = 0; i < 8; i++) cyc(I_RN | I_ST, STALL_O, "wd_stall8");
    cyc(I_RN | I_ST, HALT_O, "wd_halted");
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_set: got %b expected 1", timeout);
    end
    n_checks++;
    if (stall_cnt !== 16'd16) begin
      n_fail++; $display("FAIL stall_cnt_watchdog: got %0d expected 16", stall_cnt);
    end
    cyc(I_RN, RUN_O, "run_after_timeout");
    cyc(I_NO, RUN_O, "run_drop_after_timeout");
    cyc(I_NO, HALT_O, "halted_end_wd");
    n_checks++;
    if (timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b expected 1", timeout);
    end
  endtask

  task automatic test_midreset();
    cyc(I_RN, HALT_O, "mr_start");
    cyc(I_RN | I_ST, STALL_O, "mr_stall");
    rst_n = 1'b0;
    rst2_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== HALT_O) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected %b", obs, HALT_O);
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got %0d/%0d/%b expected 0/0/0", stall_cnt, flush_cnt, timeout);
    end
    {stall, br, halt, run, step, hreq} = I_NO;
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    cyc(I_RN, HALT_O, "sat_start");
    for (int i = 0; i < 5; i++) cyc(I_RN | I_ST, STALL_O, "sat_stall");
    for (int i = 0; i < 4; i++) cyc(I_RN | I_BR, BR_O, "sat_branch");
    cyc(I_NO, RUN_O, "sat_drop");
    cyc(I_NO, HALT_O, "sat_halted");
    n_checks++;
    if (stall_cnt2 !== 2'd3 || flush_cnt2 !== 2'd3) begin
      n_fail++; $display("FAIL sat_cnt_w2: got %0d/%0d expected 3/3", stall_cnt2, flush_cnt2);
    end
    n_checks++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd4) begin
      n_fail++; $display("FAIL cnt_w16: got %0d/%0d expected 5/4", stall_cnt, flush_cnt);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall_branch();
    test_branch();
    test_halt_drain();
    test_step();
    test_dbg_halt();
    test_watchdog();
    test_midreset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
